// File: rtl/moore_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first with a valid strobe,
// optionally repeating the frame with idle gaps, and pulses done after the last frame.
module moore_pattern_tx #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned CNT_W      = 4
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             E,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state
);

   localparam int unsigned BitW = $clog2(WIDTH);
   localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
   localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StGap   = 2'b10,
      StDone  = 2'b11
   } state_e;

   state_e           r_state, w_state;
   logic [WIDTH-1:0] r_shift, w_shift;
   logic [WIDTH-1:0] r_pat,   w_pat;
   logic [CNT_W-1:0] r_rep,   w_rep;
   logic [BitW-1:0]  r_bit,   w_bit;
   logic [GapW-1:0]  r_gap,   w_gap;
   logic             r_e,     w_e;
   logic             r_valid, w_valid;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_shift <= '0;
         r_pat   <= '0;
         r_rep   <= '0;
         r_bit   <= '0;
         r_gap   <= '0;
         r_e     <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state;
         r_shift <= w_shift;
         r_pat   <= w_pat;
         r_rep   <= w_rep;
         r_bit   <= w_bit;
         r_gap   <= w_gap;
         r_e     <= w_e;
         r_valid <= w_valid;
      end
   end

   always_comb begin
      w_state = r_state;
      w_shift = r_shift;
      w_pat   = r_pat;
      w_rep   = r_rep;
      w_bit   = r_bit;
      w_gap   = r_gap;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_pat   = pattern;
               w_rep   = repeat_n;
               w_shift = pattern;
               w_bit   = BitLast;
               w_state = StShift;
            end
         end
         StShift: begin
            w_shift = {r_shift[WIDTH-2:0], 1'b0};
            w_bit   = r_bit - BitW'(1);
            if (r_bit == '0) begin
               w_bit = '0;
               if (r_rep == '0) begin
                  w_state = StDone;
               end else begin
                  w_rep = r_rep - CNT_W'(1);
                  if (GAP_CYCLES > 0) begin
                     w_state = StGap;
                     w_gap   = GapLoad;
                  end else begin
                     // Back-to-back: reload now so valid never drops between frames.
                     w_shift = r_pat;
                     w_bit   = BitLast;
                  end
               end
            end
         end
         StGap: begin
            w_gap = r_gap - GapW'(1);
            if (r_gap == '0) begin
               w_shift = r_pat;
               w_bit   = BitLast;
               w_state = StShift;
            end
         end
         StDone: begin
            w_state = StIdle;
         end
         default: begin
            w_state = StIdle;
         end
      endcase
      // E and valid are registered copies of what the next state will present.
      w_valid = (w_state == StShift);
      w_e     = w_valid & w_shift[WIDTH-1];
   end

   assign E     = r_e;
   assign valid = r_valid;
   assign busy  = (r_state == StShift) || (r_state == StGap);
   assign done  = (r_state == StDone);
   assign state = r_state;

endmodule
